// File: rtl/gray_seq_pkg.sv
// Shared definitions for the Gray code sequencer.
//   - Sequencer state encoding.
//   - Geometry constants:
//       B_W      binary count width
//       SEQ_LEN  binary period
//       OFFSET   virtual-space offset
//       CYC_LEN  full cyclic period (two phases)
//   - Helpers that map a cycle position to its VSB word and its Gray code.
package gray_seq_pkg;

    localparam int B_W     = 4;
    localparam int SEQ_LEN = 11;
    localparam int OFFSET  = (1 << B_W) - SEQ_LEN;
    localparam int CYC_LEN = 2 * SEQ_LEN;
    localparam int POS_W   = 5;
    localparam int VSB_W   = B_W + 1;

    localparam logic [POS_W-1:0] POS_SEQ  = POS_W'(SEQ_LEN);
    localparam logic [POS_W-1:0] POS_CYC  = POS_W'(CYC_LEN);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(CYC_LEN - 1);
    localparam logic [POS_W-1:0] POS_OFF  = POS_W'(OFFSET);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Phase 1 (p < SEQ_LEN) uses the lower part of the binary space with the
    // MSB set. Phase 0 is shifted up by OFFSET, so the two halves meet at
    // mirror points of the reflected Gray code and the cycle stays single-step.
    function automatic logic [VSB_W-1:0] pos_to_vsb(input logic [POS_W-1:0] p);
        logic [POS_W-1:0] shifted;
        shifted = p - POS_SEQ + POS_OFF;
        if (p < POS_SEQ) begin
            return {1'b1, p[B_W-1:0]};
        end
        return {1'b0, shifted[B_W-1:0]};
    endfunction

    function automatic logic [VSB_W-1:0] bin2gray(input logic [VSB_W-1:0] v);
        return v ^ (v >> 1);
    endfunction

endpackage

// File: rtl/gray_pos_enc.sv
// Combinational position encoder.
// Ports:
//   pos  in   cycle position 0..CYC_LEN-1
//   f    out  phase flag (1 in the first half of the cycle)
//   b    out  binary count within the phase
//   g    out  cyclic Gray code of the position
module gray_pos_enc
    import gray_seq_pkg::*;
(
    input  logic [POS_W-1:0] pos,
    output logic             f,
    output logic [B_W-1:0]   b,
    output logic [VSB_W-1:0] g
);

    logic [VSB_W-1:0] vsb;
    logic [POS_W-1:0] pos_off;

    always_comb begin
        vsb     = pos_to_vsb(pos);
        pos_off = pos - POS_SEQ;
        f       = vsb[B_W];
        b       = f ? pos[B_W-1:0] : pos_off[B_W-1:0];
        g       = bin2gray(vsb);
    end

endmodule

// File: rtl/gray_seq_ctrl.sv
// Gray code sequencer / output controller.
// Ports:
//   CLK, RST_N        clock (rising edge), async active-low reset
//   START, STOP       one-cycle commands
//   LEN, START_POS    burst length (0 = continuous) and start position,
//                     both sampled on an accepted START
//   OUT_READY         consumer accepts the current code
//   OUT_VALID         OUT_G/OUT_B/OUT_F/POS carry a valid code
//   OUT_G/OUT_B/OUT_F Gray code, binary count and phase of POS
//   POS               current cycle position
//   BUSY, DONE, ERR   status: not idle / burst-end pulse / bad start position
module gray_seq_ctrl
    import gray_seq_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             STOP,
    input  logic [LEN_W-1:0] LEN,
    input  logic [POS_W-1:0] START_POS,
    input  logic             OUT_READY,
    output logic             OUT_VALID,
    output logic [VSB_W-1:0] OUT_G,
    output logic [B_W-1:0]   OUT_B,
    output logic             OUT_F,
    output logic [POS_W-1:0] POS,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR
);

    state_t           state_reg, state_next;
    logic [POS_W-1:0] pos_reg, pos_next;
    logic [LEN_W-1:0] rem_reg, rem_next;
    logic             valid_reg, valid_next;
    logic             done_reg, done_next;
    logic             err_reg, err_next;
    logic             busy_reg, busy_next;
    logic [VSB_W-1:0] g_reg, g_next;
    logic [B_W-1:0]   b_reg, b_next;
    logic             f_reg, f_next;
    logic             accept;

    // The encoded outputs are derived from the next position and registered
    // together with it, so they can never disagree with POS.
    gray_pos_enc u_enc (
        .pos (pos_next),
        .f   (f_next),
        .b   (b_next),
        .g   (g_next)
    );

    always_comb begin
        state_next = state_reg;
        pos_next   = pos_reg;
        rem_next   = rem_reg;
        valid_next = 1'b0;
        done_next  = 1'b0;
        err_next   = 1'b0;
        accept     = valid_reg & OUT_READY;

        case (state_reg)
            ST_IDLE: begin
                // STOP overrides a simultaneous START.
                if (START && !STOP) begin
                    state_next = ST_RUN;
                    valid_next = 1'b1;
                    rem_next   = LEN;
                    if (START_POS >= POS_CYC) begin
                        pos_next = '0;
                        err_next = 1'b1;
                    end else begin
                        pos_next = START_POS;
                    end
                end
            end
            ST_RUN: begin
                valid_next = 1'b1;
                if (accept) begin
                    pos_next = (pos_reg == POS_LAST) ? '0 : pos_reg + POS_W'(1);
                    // A zero remaining count means continuous mode.
                    if (rem_reg != '0) begin
                        rem_next = rem_reg - LEN_W'(1);
                        if (rem_reg == LEN_W'(1)) begin
                            state_next = ST_DONE;
                        end
                    end
                end
                if (STOP) begin
                    state_next = ST_DONE;
                end
                // Leaving RUN withdraws any unaccepted code.
                if (state_next == ST_DONE) begin
                    valid_next = 1'b0;
                    done_next  = 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= ST_IDLE;
            pos_reg   <= '0;
            rem_reg   <= '0;
            valid_reg <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            g_reg     <= bin2gray(VSB_W'(1 << B_W));
            b_reg     <= '0;
            f_reg     <= 1'b1;
        end else begin
            state_reg <= state_next;
            pos_reg   <= pos_next;
            rem_reg   <= rem_next;
            valid_reg <= valid_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
            busy_reg  <= busy_next;
            g_reg     <= g_next;
            b_reg     <= b_next;
            f_reg     <= f_next;
        end
    end

    assign OUT_VALID = valid_reg;
    assign OUT_G     = g_reg;
    assign OUT_B     = b_reg;
    assign OUT_F     = f_reg;
    assign POS       = pos_reg;
    assign BUSY      = busy_reg;
    assign DONE      = done_reg;
    assign ERR       = err_reg;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
module tb_gray_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [7:0] len;
    logic [4:0] start_pos;
    logic       ready;
    logic       out_valid;
    logic [4:0] out_g;
    logic [3:0] out_b;
    logic       out_f;
    logic [4:0] pos;
    logic       busy;
    logic       done;
    logic       err;

    int n_vec = 0;
    int n_err = 0;

    gray_seq_ctrl dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .START     (start),
        .STOP      (stop),
        .LEN       (len),
        .START_POS (start_pos),
        .OUT_READY (ready),
        .OUT_VALID (out_valid),
        .OUT_G     (out_g),
        .OUT_B     (out_b),
        .OUT_F     (out_f),
        .POS       (pos),
        .BUSY      (busy),
        .DONE      (done),
        .ERR       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       stop;
        logic [7:0] len;
        logic [4:0] spos;
        logic       ready;
        logic       valid;
        logic [4:0] g;
        logic [4:0] pos;
        logic       f;
        logic [3:0] b;
        logic       done;
        logic       busy;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, input logic sp, input logic [7:0] ln,
                       input logic [4:0] spos, input logic rdy,
                       input logic v, input logic [4:0] g, input logic [4:0] p,
                       input logic f, input logic [3:0] b,
                       input logic d, input logic bs, input logic e);
        vec_t r;
        r.start = st; r.stop = sp; r.len = ln; r.spos = spos; r.ready = rdy;
        r.valid = v; r.g = g; r.pos = p; r.f = f; r.b = b;
        r.done = d; r.busy = bs; r.err = e;
        vecs.push_back(r);
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s vec %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [4:0] g,
                           input logic [4:0] p, input logic f, input logic [3:0] b,
                           input logic d, input logic bs, input logic e);
        int idx;
        idx = n_vec;
        n_vec++;
        chk({tag, ".valid"}, idx, 32'(out_valid), 32'(v));
        chk({tag, ".g"},     idx, 32'(out_g),     32'(g));
        chk({tag, ".pos"},   idx, 32'(pos),       32'(p));
        chk({tag, ".f"},     idx, 32'(out_f),     32'(f));
        chk({tag, ".b"},     idx, 32'(out_b),     32'(b));
        chk({tag, ".done"},  idx, 32'(done),      32'(d));
        chk({tag, ".busy"},  idx, 32'(busy),      32'(bs));
        chk({tag, ".err"},   idx, 32'(err),       32'(e));
        $display("vec %0d %s: valid=%0d g=0x%02h pos=%0d f=%0d b=%0d done=%0d busy=%0d err=%0d",
                 idx, tag, out_valid, out_g, pos, out_f, out_b, done, busy, err);
    endtask

    task automatic drive(input logic st, input logic sp, input logic [7:0] ln,
                         input logic [4:0] spos, input logic rdy);
        start = st; stop = sp; len = ln; start_pos = spos; ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] prev_g;
        logic [4:0] prev_pos;
        logic [4:0] exp_pos;

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 8'd0, 5'd0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 5'h18, 5'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_all("idle", 1'b0, 5'h18, 5'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);

        // st sp len spos rdy | valid g pos f b done busy err
        // burst of 3 from 0
        add(1, 0, 8'd3, 5'd0,  1, 1, 5'h18, 5'd0,  1, 4'd0,  0, 1, 0);
        add(0, 0, 8'd0, 5'd0,  1, 1, 5'h19, 5'd1,  1, 4'd1,  0, 1, 0);
        add(0, 0, 8'd0, 5'd0,  1, 1, 5'h1B, 5'd2,  1, 4'd2,  0, 1, 0);
        add(0, 0, 8'd0, 5'd0,  1, 0, 5'h1A, 5'd3,  1, 4'd3,  1, 1, 0);
        add(0, 0, 8'd0, 5'd0,  1, 0, 5'h1A, 5'd3,  1, 4'd3,  0, 0, 0);
        // wrap across the phase boundary
        add(1, 0, 8'd2, 5'd10, 1, 1, 5'h17, 5'd10, 1, 4'd10, 0, 1, 0);
        add(0, 0, 8'd0, 5'd0,  1, 1, 5'h07, 5'd11, 0, 4'd0,  0, 1, 0);
        add(0, 0, 8'd0, 5'd0,  1, 0, 5'h05, 5'd12, 0, 4'd1,  1, 1, 0);
        add(0, 0, 8'd0, 5'd0,  1, 0, 5'h05, 5'd12, 0, 4'd1,  0, 0, 0);
        // wrap across the end of the cycle
        add(1, 0, 8'd2, 5'd21, 1, 1, 5'h08, 5'd21, 0, 4'd10, 0, 1, 0);
        add(0, 0, 8'd0, 5'd0,  1, 1, 5'h18, 5'd0,  1, 4'd0,  0, 1, 0);
        add(0, 0, 8'd0, 5'd0,  1, 0, 5'h19, 5'd1,  1, 4'd1,  1, 1, 0);
        add(0, 0, 8'd0, 5'd0,  1, 0, 5'h19, 5'd1,  1, 4'd1,  0, 0, 0);
        // START with STOP in idle: nothing happens
        add(1, 1, 8'd3, 5'd5,  1, 0, 5'h19, 5'd1,  1, 4'd1,  0, 0, 0);
        add(0, 0, 8'd0, 5'd0,  1, 0, 5'h19, 5'd1,  1, 4'd1,  0, 0, 0);
        // out-of-range start, then an ignored START during RUN
        add(1, 0, 8'd2, 5'd22, 1, 1, 5'h18, 5'd0,  1, 4'd0,  0, 1, 1);
        add(1, 0, 8'd5, 5'd7,  1, 1, 5'h19, 5'd1,  1, 4'd1,  0, 1, 0);
        add(0, 0, 8'd0, 5'd0,  1, 0, 5'h1B, 5'd2,  1, 4'd2,  1, 1, 0);
        add(0, 0, 8'd0, 5'd0,  1, 0, 5'h1B, 5'd2,  1, 4'd2,  0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].start, vecs[i].stop, vecs[i].len, vecs[i].spos, vecs[i].ready);
            tick();
            chk_all("table", vecs[i].valid, vecs[i].g, vecs[i].pos, vecs[i].f,
                    vecs[i].b, vecs[i].done, vecs[i].busy, vecs[i].err);
        end

        // Backpressure on the second code of a continuous run.
        drive(1'b1, 1'b0, 8'd0, 5'd0, 1'b1);
        tick();
        chk_all("bp_first", 1'b1, 5'h18, 5'd0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 8'd0, 5'd0, 1'b1);
        tick();
        chk_all("bp_second", 1'b1, 5'h19, 5'd1, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0);
        ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_all("bp_hold", 1'b1, 5'h19, 5'd1, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0);
        end
        ready = 1'b1;
        tick();
        chk_all("bp_release", 1'b1, 5'h1B, 5'd2, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0);

        // Single-bit-change property over 50 codes, including both wraps.
        for (int k = 0; k < 50; k++) begin
            prev_g   = out_g;
            prev_pos = pos;
            exp_pos  = (prev_pos == 5'd21) ? 5'd0 : prev_pos + 5'd1;
            tick();
            n_vec++;
            chk("onebit", n_vec, 32'($countones(out_g ^ prev_g)), 32'd1);
            chk("pos_step", n_vec, 32'(pos), 32'(exp_pos));
            chk("cont_valid", n_vec, 32'(out_valid), 32'd1);
            $display("vec %0d onebit: g=0x%02h prev=0x%02h pos=%0d", n_vec, out_g, prev_g, pos);
        end

        // STOP while the consumer stalls: code withdrawn, position not advanced.
        drive(1'b0, 1'b1, 8'd0, 5'd0, 1'b0);
        tick();
        chk_all("stop_stall", 1'b0, 5'h14, 5'd8, 1'b1, 4'd8, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 8'd0, 5'd0, 1'b1);
        tick();
        chk_all("stop_idle", 1'b0, 5'h14, 5'd8, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a continuous run.
        drive(1'b1, 1'b0, 8'd0, 5'd5, 1'b1);
        tick();
        drive(1'b0, 1'b0, 8'd0, 5'd0, 1'b1);
        tick();
        chk_all("pre_reset", 1'b1, 5'h1D, 5'd6, 1'b1, 4'd6, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 5'h18, 5'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) tick();
        chk_all("post_reset", 1'b0, 5'h18, 5'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
